// File: rtl/note_seq_pkg.sv
// Shared types and default timing constants for the note sequencer and its buffer.
package note_seq_pkg;
    localparam int NOTE_W          = 3;
    localparam int DEF_NOTE_CYCLES = 25_000_000;  // 0.5 s at 50 MHz
    localparam int DEF_GAP_CYCLES  = 12_500_000;  // 0.25 s at 50 MHz

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;
endpackage

// File: rtl/note_seq_buffer.sv
// MAX_LEN x NOTE_W register file holding the note sequence, with append and fill tracking.
module note_seq_buffer
    import note_seq_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic [NOTE_W-1:0] push_note,
    input  logic [LEN_W-1:0]  rd_idx,
    output logic [NOTE_W-1:0] rd_note,
    output logic [LEN_W-1:0]  len,
    output logic              full
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [NOTE_W-1:0] mem [MAX_LEN];
    logic              wr_en;

    assign wr_en = push && !full && !clear;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len  <= '0;
            full <= 1'b0;
        end else if (clear) begin
            len  <= '0;
            full <= 1'b0;
        end else if (wr_en) begin
            len  <= len + LEN_W'(1);
            full <= (len + LEN_W'(1)) == LEN_W'(MAX_LEN);
        end
    end

    // Contents are not reset; len alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            mem[len[IDX_W-1:0]] <= push_note;
        end
    end

    // The sequencer looks one entry past the end on the last note; return 0 there.
    assign rd_note = (rd_idx < LEN_W'(MAX_LEN)) ? mem[rd_idx[IDX_W-1:0]] : '0;
endmodule

// File: rtl/note_sequencer.sv
// Plays a stored note sequence as timed tone/gap intervals into the tone generator.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int NOTE_CYCLES = DEF_NOTE_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int CNT_W       = 25,
    parameter int LEN_W       = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic [NOTE_W-1:0] push_note,
    input  logic              start,
    input  logic              abort,
    output logic [NOTE_W-1:0] note,
    output logic              en,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  len,
    output logic              full,
    output logic [LEN_W-1:0]  play_idx
);
    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [LEN_W-1:0]  rd_idx;
    logic [NOTE_W-1:0] rd_note;
    logic              last_note;

    // In IDLE the buffer is read at 0 for start; while playing it is read one ahead.
    assign rd_idx    = (state == IDLE) ? '0 : play_idx + LEN_W'(1);
    assign last_note = (play_idx + LEN_W'(1)) >= len;

    note_seq_buffer #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (push && (state == IDLE)),
        .push_note (push_note),
        .rd_idx    (rd_idx),
        .rd_note   (rd_note),
        .len       (len),
        .full      (full)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            play_idx <= '0;
            note     <= '0;
            en       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear || (abort && state != IDLE)) begin
                state    <= IDLE;
                cnt      <= '0;
                play_idx <= '0;
                note     <= '0;
                en       <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && len != '0) begin
                            state    <= TONE;
                            cnt      <= '0;
                            play_idx <= '0;
                            note     <= rd_note;
                            en       <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                    TONE, GAP: begin
                        if (state == TONE && cnt != NOTE_LAST) begin
                            cnt <= cnt + CNT_W'(1);
                        end else if (state == GAP && cnt != GAP_LAST) begin
                            cnt <= cnt + CNT_W'(1);
                        end else if (state == TONE && GAP_CYCLES > 0) begin
                            state <= GAP;
                            cnt   <= '0;
                            en    <= 1'b0;
                        end else if (!last_note) begin
                            // Interval finished with notes remaining: advance to the next tone.
                            state    <= TONE;
                            cnt      <= '0;
                            play_idx <= play_idx + LEN_W'(1);
                            note     <= rd_note;
                            en       <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            cnt      <= '0;
                            play_idx <= '0;
                            note     <= '0;
                            en       <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        cnt      <= '0;
                        play_idx <= '0;
                        note     <= '0;
                        en       <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: scoreboard of expected notes per playback.
module tb_note_sequencer;
    localparam int NC    = 4;
    localparam int GC    = 2;
    localparam int MAXL  = 4;
    localparam int LEN_W = 3;

    logic             clk;
    logic             reset_n;
    logic             clear;
    logic             push;
    logic [2:0]       push_note;
    logic             start;
    logic             abort;
    logic [2:0]       note;
    logic             en;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] len;
    logic             full;
    logic [LEN_W-1:0] play_idx;

    int tests;
    int fails;

    logic [2:0] m_seq[$];   // model of the stored sequence
    logic [2:0] exp_q[$];   // notes expected from the current playback

    note_sequencer #(
        .MAX_LEN     (MAXL),
        .NOTE_CYCLES (NC),
        .GAP_CYCLES  (GC),
        .CNT_W       (3),
        .LEN_W       (LEN_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (push),
        .push_note (push_note),
        .start     (start),
        .abort     (abort),
        .note      (note),
        .en        (en),
        .busy      (busy),
        .done      (done),
        .len       (len),
        .full      (full),
        .play_idx  (play_idx)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic do_push(input logic [2:0] n);
        push      = 1'b1;
        push_note = n;
        step();
        push = 1'b0;
        if (m_seq.size() < MAXL) m_seq.push_back(n);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        m_seq.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_q.delete();
        foreach (m_seq[i]) exp_q.push_back(m_seq[i]);
    endtask

    task automatic check_len(input string name, input int exp_len, input logic exp_full);
        tests++;
        if (len !== LEN_W'(exp_len) || full !== exp_full) begin
            fails++;
            $display("FAIL %s: len=%0d full=%b, expected len=%0d full=%b", name, len, full, exp_len, exp_full);
        end
    endtask

    task automatic check_idle(input string name);
        tests++;
        if (en !== 1'b0 || note !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || play_idx !== '0) begin
            fails++;
            $display("FAIL %s: en=%b note=%0d busy=%b done=%b idx=%0d, expected all 0",
                     name, en, note, busy, done, play_idx);
        end
    endtask

    // Checks every cycle of a playback already started; done must land on the
    // (len*(NC+GC)+1)-th edge counting the edge that sampled start as the first.
    task automatic run_playback(input string name, input int disturb_at);
        int k;
        int cyc;
        logic [2:0] exp_note;
        k   = 0;
        cyc = 0;
        while (exp_q.size() > 0) begin
            exp_note = exp_q.pop_front();
            for (int c = 0; c < NC + GC; c++) begin
                tests++;
                if (en !== (c < NC) || note !== exp_note || busy !== 1'b1 || done !== 1'b0 ||
                    play_idx !== LEN_W'(k)) begin
                    fails++;
                    $display("FAIL %s note%0d cyc%0d: en=%b note=%0d busy=%b done=%b idx=%0d, expected en=%b note=%0d busy=1 done=0 idx=%0d",
                             name, k, c, en, note, busy, done, play_idx, (c < NC), exp_note, k);
                end
                if (cyc == disturb_at) begin
                    push      = 1'b1;
                    push_note = 3'd1;
                    start     = 1'b1;
                end
                step();
                push  = 1'b0;
                start = 1'b0;
                cyc++;
            end
            k++;
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || en !== 1'b0 || note !== 3'd0 || play_idx !== '0) begin
            fails++;
            $display("FAIL %s end: done=%b busy=%b en=%b note=%0d idx=%0d, expected done=1 busy=0 en=0 note=0 idx=0",
                     name, done, busy, en, note, play_idx);
        end
        step();
        check_idle({name, " after done"});
    endtask

    // test scenarios
    task automatic test_reset();
        reset_n   = 1'b0;
        push      = 1'b1;
        push_note = 3'd5;
        step();
        step();
        check_idle("reset outputs");
        check_len("reset len", 0, 1'b0);
        reset_n = 1'b1;
        push    = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check_idle("reset nothing stored");
        step();
        check_idle("reset nothing stored +1");
    endtask

    task automatic test_playback();
        do_push(3'd5);
        do_push(3'd2);
        do_push(3'd7);
        check_len("push 3", 3, 1'b0);
        do_start();
        run_playback("play 5,2,7", -1);
    endtask

    task automatic test_overflow();
        do_clear();
        check_len("clear", 0, 1'b0);
        do_push(3'd1);
        do_push(3'd2);
        do_push(3'd3);
        do_push(3'd4);
        do_push(3'd6);
        check_len("overflow", 4, 1'b1);
        do_start();
        run_playback("play full", -1);
        check_len("overflow after play", 4, 1'b1);
    endtask

    task automatic test_abort();
        do_start();
        for (int i = 0; i < NC + GC + 1; i++) step();
        tests++;
        if (en !== 1'b1 || note !== 3'd2 || play_idx !== LEN_W'(1)) begin
            fails++;
            $display("FAIL abort pre: en=%b note=%0d idx=%0d, expected en=1 note=2 idx=1", en, note, play_idx);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_q.delete();
        check_idle("abort");
        check_len("abort len", 4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("abort no done");
        end
        do_start();
        run_playback("replay after abort", -1);
    endtask

    task automatic test_ignored();
        do_clear();
        start = 1'b1;
        step();
        start = 1'b0;
        check_idle("start empty");
        step();
        check_idle("start empty +1");
        do_push(3'd3);
        do_push(3'd6);
        do_start();
        run_playback("push/start while busy", 2);
        check_len("len after busy push", 2, 1'b0);
    endtask

    task automatic test_clear();
        clear     = 1'b1;
        push      = 1'b1;
        push_note = 3'd7;
        step();
        clear = 1'b0;
        push  = 1'b0;
        m_seq.delete();
        check_len("clear+push", 0, 1'b0);
        do_push(3'd4);
        do_push(3'd0);
        do_start();
        for (int i = 0; i < NC; i++) step();
        tests++;
        if (en !== 1'b0 || busy !== 1'b1 || note !== 3'd4) begin
            fails++;
            $display("FAIL clear pre: en=%b busy=%b note=%0d, expected en=0 busy=1 note=4", en, busy, note);
        end
        do_clear();
        exp_q.delete();
        check_idle("clear in gap");
        check_len("clear in gap len", 0, 1'b0);
        step();
        check_idle("clear in gap no done");
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset_n   = 1'b0;
        clear     = 1'b0;
        push      = 1'b0;
        push_note = 3'd0;
        start     = 1'b0;
        abort     = 1'b0;
        test_reset();
        test_playback();
        test_overflow();
        test_abort();
        test_ignored();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream of the tone generator.
- Stores a Simon Says note sequence and plays it back: it drives the tone generator's 3-bit note and en inputs with timed tone and gap intervals.
- Game logic loads the sequence via push, then pulses start; done pulses when playback ends.

Parameters:
MAX_LEN, 16, sequence buffer depth in notes
NOTE_CYCLES, 25000000, clk cycles en is held high per note (0.5 s at 50 MHz)
GAP_CYCLES, 12500000, clk cycles of silence after each note
CNT_W, 25, duration counter width; must hold max(NOTE_CYCLES, GAP_CYCLES)-1
LEN_W, 5, width of len/play_idx; must hold MAX_LEN

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  synchronous, active-low reset
clear  in  1  empty the buffer; aborts playback if busy
push  in  1  append push_note to buffer
push_note  in  3  note code 0..7 to append
start  in  1  begin playback from index 0
abort  in  1  stop playback immediately
note  out  3  note code to tone generator
en  out  1  tone enable to tone generator
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse at normal end of playback
len  out  LEN_W  notes currently stored
full  out  1  len == MAX_LEN
play_idx  out  LEN_W  index of the note being played; 0 in IDLE

Behaviour:
- Reset (reset_n low at a clk edge) is synchronous and active-low. It sets the state to IDLE, len=0, note=0, en=0, busy=0, done=0, play_idx=0 and the counter to 0. Buffer contents need not be cleared.
- States: IDLE, TONE, GAP.
- All outputs are registered.
- IDLE:
  - en=0, note=0.
  - push with !full writes buf[len] and increments len. push while full is ignored.
  - start with len>0: next cycle TONE, play_idx=0, note=buf[0], en=1, counter=0.
  - start with len==0 is ignored and gives no done.
- TONE:
  - en=1 and note=buf[play_idx] for exactly NOTE_CYCLES cycles.
  - Then GAP with en=0; note keeps its value.
- GAP:
  - Lasts exactly GAP_CYCLES cycles.
  - If play_idx < len-1: go to TONE with play_idx+1.
  - Otherwise: go to IDLE, with done=1 for one cycle on the first IDLE cycle, note=0, play_idx=0.
- GAP_CYCLES=0 is legal: TONE goes directly to the next TONE or to IDLE.
- Total playback time from start to done = len*(NOTE_CYCLES+GAP_CYCLES)+1 cycles.
- Busy-state inputs:
  - push and start are ignored while busy.
  - The buffer is not modified during playback.
- Abort:
  - abort while busy: next cycle IDLE, en=0, note=0, no done. len is preserved.
  - abort in IDLE: no effect.
- clear:
  - Sets len=0 next cycle in any state; if busy, behaves as abort.
  - clear and push in the same cycle: clear wins, len=0.
  - clear has priority over abort, start and push.
- The sequence can be replayed (start again) without reloading.
- Simon Says usage: game logic pushes one new note per round and replays.

Decomposition:
- Shared package note_seq_pkg:
  - NOTE_W=3
  - state enum {IDLE, TONE, GAP}
  - default NOTE_CYCLES and GAP_CYCLES constants at 50 MHz
- Sub-module note_seq_buffer: MAX_LEN x 3 register file.
  - Ports: clk, reset_n, clear, push, push_note, rd_idx, rd_note, len, full.
  - Contains the push/len/full logic.
- The FSM and duration counter live in note_sequencer.

Test Plan:
Bench parameters for all scenarios: NOTE_CYCLES=4, GAP_CYCLES=2, MAX_LEN=4.
1. Reset: hold reset_n=0 for 2 cycles with push=1 -> len=0, en=0, note=0, busy=0, done=0; nothing stored.
2. Push notes 5,2,7 then start -> en high 4 cycles with note=5, low 2, high 4 with note=2, low 2, high 4 with note=7, low 2. done pulses exactly 1 cycle, 19 cycles after the start edge; busy=0 at the done cycle.
3. Fill/overflow: push 1,2,3,4,6 -> len=4, full=1; playback plays 1,2,3,4 only.
4. Abort during the second TONE -> next cycle en=0, note=0, busy=0, no done. len unchanged, and a following start replays from index 0.
5. Ignored inputs:
   - start with len=0 -> busy stays 0, no done.
   - push during playback -> len unchanged.
   - start during playback -> the sequence is not restarted.
6. clear and push asserted in the same IDLE cycle -> len=0. clear during GAP -> IDLE next cycle, len=0, no done.
